// File: rtl/serial_tx_framer.sv
// serial_tx_framer: 8N1 UART transmitter with a synchronised hold-off input.
// Accepts one byte per strobe while idle; tx_busy rises on the acceptance edge.
module serial_tx_framer #(
    parameter int CLK_PER_BIT = 100,
    parameter int CTR_SIZE    = 7
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tx,
    input  logic       block,
    output logic       tx_busy,
    input  logic [7:0] tx_data,
    input  logic       new_tx_data
);

    localparam logic [CTR_SIZE-1:0] CTR_MAX = CTR_SIZE'(CLK_PER_BIT - 1);
    localparam logic [CTR_SIZE-1:0] CTR_ONE = CTR_SIZE'(1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT
    } state_t;

    state_t              state_q, state_d;
    logic [CTR_SIZE-1:0] ctr_q, ctr_d;
    logic [2:0]          bit_ctr_q, bit_ctr_d;
    logic [7:0]          data_q, data_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                blk_meta_q, blk_meta_d;
    logic                blk_s_q, blk_s_d;

    logic                wrap;
    logic [CTR_SIZE-1:0] ctr_inc;
    logic [2:0]          nxt_bit;

    assign tx      = tx_q;
    assign tx_busy = busy_q;

    assign wrap    = (ctr_q == CTR_MAX);
    assign ctr_inc = ctr_q + CTR_ONE;
    assign nxt_bit = bit_ctr_q + 3'd1;

    // Two-flop synchroniser for the asynchronous hold-off request.
    always_comb begin
        blk_meta_d = block;
        blk_s_d    = blk_meta_q;
    end

    // Next-state and output logic; every bit period ends on ctr wrap.
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        bit_ctr_d = bit_ctr_q;
        data_d    = data_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = blk_s_q;
                if (new_tx_data && !busy_q) begin
                    data_d    = tx_data;
                    bit_ctr_d = 3'd0;
                    ctr_d     = '0;
                    state_d   = START_BIT;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            START_BIT: begin
                if (wrap) begin
                    ctr_d   = '0;
                    tx_d    = data_q[0];
                    state_d = DATA;
                end else begin
                    ctr_d = ctr_inc;
                end
            end

            DATA: begin
                if (wrap) begin
                    ctr_d = '0;
                    if (bit_ctr_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP_BIT;
                    end else begin
                        tx_d      = data_q[nxt_bit];
                        bit_ctr_d = nxt_bit;
                    end
                end else begin
                    ctr_d = ctr_inc;
                end
            end

            STOP_BIT: begin
                tx_d = 1'b1;
                if (wrap) begin
                    ctr_d   = '0;
                    state_d = IDLE;
                    busy_d  = blk_s_q;
                end else begin
                    ctr_d = ctr_inc;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ctr_d   = '0;
            end
        endcase
    end

    // State register; reset parks the line idle and drops any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ctr_q      <= '0;
            bit_ctr_q  <= 3'd0;
            data_q     <= 8'h00;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            blk_meta_q <= 1'b0;
            blk_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            bit_ctr_q  <= bit_ctr_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            blk_meta_q <= blk_meta_d;
            blk_s_q    <= blk_s_d;
        end
    end

endmodule

// File: doc/serial_tx_framer.md
Name: serial_tx_framer

Overview:
- UART transmitter sitting directly downstream of the message printer.
- Accepts one byte per `new_tx_data` strobe and serialises it as 8N1 (start bit, 8 data bits LSB first, stop bit) on the `tx` pin.
- Reports `tx_busy` back to the producer.
- An external `block` input (e.g. host/AVR not ready) holds off new frames without truncating a frame in progress.

Parameters:
- CLK_PER_BIT, 100, clk cycles per serial bit; legal range 2..2^CTR_SIZE.
- CTR_SIZE, 7, width of the bit-period counter; must satisfy 2^CTR_SIZE >= CLK_PER_BIT.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx  output  1  serial line, registered; idle level 1.
- block  input  1  asynchronous hold-off request; synchronised internally.
- tx_busy  output  1  registered; 1 = byte not accepted this cycle.
- tx_data  input  8  byte to send; sampled only on acceptance.
- new_tx_data  input  1  single-cycle send strobe; may be combinationally derived from `tx_busy` by the producer.

Behaviour:
- Reset (async, active-high): `tx`=1, `tx_busy`=0, state=IDLE, counters=0, shift register=0, block synchroniser flops=0.
- block sync: two-flop synchroniser; block_s lags `block` by 2 clk edges.
- States: IDLE, START_BIT, DATA, STOP_BIT.
- IDLE:
  - `tx`=1.
  - `tx_busy` next = block_s.
  - If `new_tx_data`=1 and `tx_busy`=0 at an edge:
    - `tx_data` is latched into the shift register.
    - bit_ctr=0, ctr=0.
    - state→START_BIT.
    - `tx`←0 and `tx_busy`←1, both on that same edge.
- Acceptance rule: `tx_busy` must read 1 in the cycle immediately after acceptance, so a producer that strobes whenever `tx_busy`=0 never issues two bytes for one frame.
- Ignored strobes: `new_tx_data` while `tx_busy`=1 is ignored; the byte is dropped; no error flag.
- Each of START_BIT, DATA (per bit), STOP_BIT holds `tx` for exactly CLK_PER_BIT cycles:
  - ctr counts 0..CLK_PER_BIT-1.
  - At ctr=CLK_PER_BIT-1 it wraps to 0 and the next bit is driven on that edge.
- START_BIT: `tx`=0; at wrap, `tx`←data[0], state→DATA.
- DATA:
  - bit_ctr 0..7.
  - At wrap with bit_ctr<7: `tx`←data[bit_ctr+1], bit_ctr+1.
  - At wrap with bit_ctr=7: `tx`←1, state→STOP_BIT.
- STOP_BIT: `tx`=1; at wrap, state→IDLE and `tx_busy`←block_s on the same edge.
- Frame timing: `tx_busy` is high for exactly 10·CLK_PER_BIT cycles per frame when block_s=0.
- Back-to-back frames: a strobe in the first cycle `tx_busy`=0 starts a new start bit on the following edge. There is no idle gap beyond that one cycle of `tx`=1.
- block_s=1 while a frame is in progress:
  - The frame completes unchanged.
  - On return to IDLE, `tx_busy` stays 1 until block_s=0.
  - The frame is never truncated.
- Post-acceptance data changes: changes on `tx_data` after acceptance do not affect the frame in progress.
- Reset mid-frame: `tx` returns to 1 and `tx_busy` to 0 immediately (async). The partial frame is abandoned; no resume.
- Width rules: ctr is CTR_SIZE bits; bit_ctr is 3 bits. No arithmetic overflow is reachable for legal parameters.

Test Plan:
- Reset: assert `rst` mid-cycle → `tx`=1, `tx_busy`=0 asynchronously, before the next clk edge; hold 5 cycles with no `tx` activity.
- Single byte, CLK_PER_BIT=4: `tx_data`=0x68 with a 1-cycle strobe →
  - `tx_busy`=1 the next cycle;
  - `tx` sequence per 4-cycle bit is 0, 0,0,0,1,0,1,1,0, 1;
  - `tx_busy` high for exactly 40 cycles.
- Busy drop: strobe 0x55 during an active frame (e.g. cycle 10 of a 0x68 frame) → 0x55 never appears on `tx`; the 0x68 waveform is unchanged.
- Back-to-back: producer strobes whenever `tx_busy`=0 with a 14-byte sequence →
  - 14 contiguous frames are received, decoded byte-exact;
  - exactly one idle cycle separates consecutive frames;
  - no byte is duplicated or skipped.
- Block: assert `block` at frame cycle 12 →
  - the frame finishes at cycle 40;
  - `tx_busy` stays 1 while `block`=1;
  - after `block` deasserts, `tx_busy` falls 2–3 cycles later and the next strobe is accepted.
- Reset mid-frame: assert `rst` during the DATA state → `tx`=1 immediately. After release, a new strobe of 0xA5 produces a clean full frame with correct bits.
